reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package reg_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } arb_state_e;

   localparam int unsigned REG_W     = 16;
   localparam int unsigned REG_IDX_W = 3;
   localparam int unsigned NUM_REGS  = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first valid requester at or above ptr, wrapping modulo N.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);

   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         int unsigned j;
         logic [PW-1:0] jj;
         j = 32'(ptr) + i;
         if (j >= N) j = j - N;
         jj = PW'(j);
         if (!found && valid[jj]) begin
            found     = 1'b1;
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for register-file writes, with an 8-cycle clear sequence
// that zeroes every register and takes priority over pending requests.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][REG_IDX_W-1:0]   req_dr,
   input  logic [NUM_REQ-1:0][REG_W-1:0]       req_data,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic                                clr_start,
   output logic                                clr_busy,
   output logic                                LD_REG,
   output logic [REG_IDX_W-1:0]                DR,
   output logic [REG_W-1:0]                    Bus
);

   arb_state_e           state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [REG_IDX_W-1:0] cnt_q, cnt_d;
   logic                 ld_q, ld_d;
   logic [REG_IDX_W-1:0] dr_q, dr_d;
   logic [REG_W-1:0]     bus_q, bus_d;
   logic                 clr_busy_q, clr_busy_d;

   logic [NUM_REQ-1:0]   grant;
   logic [PTR_W-1:0]     grant_idx;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_rr_pick (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (grant_idx)
   );

   // Next-state, write-port and handshake decode.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      ld_d      = 1'b0;
      dr_d      = dr_q;
      bus_d     = bus_q;
      req_ready = '0;
      case (state_q)
         ARB: begin
            if (clr_start) begin
               cnt_d   = '0;
               state_d = CLEAR;
            end else begin
               req_ready = grant & {NUM_REQ{Reset}};
               if (|grant) begin
                  ld_d     = 1'b1;
                  dr_d     = req_dr[grant_idx];
                  bus_d    = req_data[grant_idx];
                  rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                : grant_idx + PTR_W'(1);
               end
            end
         end
         CLEAR: begin
            ld_d  = 1'b1;
            dr_d  = cnt_q;
            bus_d = '0;
            cnt_d = cnt_q + REG_IDX_W'(1);
            if (cnt_q == REG_IDX_W'(NUM_REGS - 1)) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
      clr_busy_d = (state_d == CLEAR);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ARB;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         ld_q       <= 1'b0;
         dr_q       <= '0;
         bus_q      <= '0;
         clr_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         ld_q       <= ld_d;
         dr_q       <= dr_d;
         bus_q      <= bus_d;
         clr_busy_q <= clr_busy_d;
      end
   end

   assign LD_REG   = ld_q;
   assign DR       = dr_q;
   assign Bus      = bus_q;
   assign clr_busy = clr_busy_q;

endmodule
